// File: rtl/uart_rx_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter uses the same baud constant so both ends stay matched.
package uart_rx_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line.
// Presets to 1 so a reset line looks idle, not like a start bit.
module uart_rx_sync (
  input  logic dblclk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge dblclk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with holding register, ready/ack handshake,
// overrun and framing-error flags, and a nibble view for the 4-bit CPU.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = 8
) (
  input  logic       dblclk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  input  logic       nibble_sel,
  output logic [7:0] data_out,
  output logic [3:0] nibble_out,
  output logic       ready,
  output logic       overrun,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic rxs;

  rx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       ovr_q, ovr_d;
  logic       fe_q, fe_d;
  logic       stop_hit;

  uart_rx_sync u_sync (
    .dblclk  (dblclk),
    .reset   (reset),
    .async_i (rx),
    .sync_o  (rxs)
  );

  always_ff @(posedge dblclk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ovr_q     <= ovr_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    ovr_d     = ovr_q;
    fe_d      = fe_q;
    stop_hit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      START: begin
        // Half-bit wait re-centres sampling on the middle of each bit.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          stop_hit = 1'b1;
          state_d  = rxs ? IDLE : BREAK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clears first so that a same-cycle set event wins.
    if (rd_ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      fe_d    = 1'b0;
    end
    if (stop_hit && rxs) begin
      if (!ready_q || rd_ack) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (stop_hit && !rxs) fe_d = 1'b1;
  end

  assign data_out   = data_q;
  assign nibble_out = nibble_sel ? data_q[7:4] : data_q[3:0];
  assign ready      = ready_q;
  assign overrun    = ovr_q;
  assign frame_err  = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: transaction-level model of the holding register and
// flags for the CLKS_PER_BIT=4 instance, plus literal checks on both instances.
module tb_uart_rx;

  logic       dblclk = 1'b0;
  logic       reset = 1'b0;
  logic       rx4 = 1'b1;
  logic       rx16 = 1'b1;
  logic       rd_ack = 1'b0;
  logic       nibble_sel = 1'b0;
  logic [7:0] d4, d16;
  logic [3:0] n4, n16;
  logic       r4, r16, o4, o16, f4, f16;

  always #5 dblclk = ~dblclk;

  uart_rx #(.CLKS_PER_BIT(4), .CNT_W(8)) u4 (
    .dblclk(dblclk), .reset(reset), .rx(rx4), .rd_ack(rd_ack),
    .nibble_sel(nibble_sel), .data_out(d4), .nibble_out(n4),
    .ready(r4), .overrun(o4), .frame_err(f4)
  );

  uart_rx #(.CLKS_PER_BIT(16), .CNT_W(8)) u16 (
    .dblclk(dblclk), .reset(reset), .rx(rx16), .rd_ack(rd_ack),
    .nibble_sel(nibble_sel), .data_out(d16), .nibble_out(n16),
    .ready(r16), .overrun(o16), .frame_err(f16)
  );

  typedef struct {
    longint     at;
    bit         good;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  longint     cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle on which a frame whose start bit is driven now has its stop bit judged.
  function automatic longint frame_done(input int c);
    return cyc + 3 + c / 2 + 9 * c;
  endfunction

  // Model: frame outcomes land on known cycles; acks clear, same-cycle sets win.
  initial begin
    forever begin
      @(posedge dblclk);
      cyc++;
      if (!reset) begin
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
        evq.delete();
      end else begin
        bit   ack;
        bit   have;
        ev_t  e;
        logic nr, no, nf;
        ack  = rd_ack;
        have = 1'b0;
        if (evq.size() > 0 && evq[0].at == cyc) begin
          e    = evq.pop_front();
          have = 1'b1;
        end
        nr = m_ready; no = m_ovr; nf = m_fe;
        if (ack) begin nr = 1'b0; no = 1'b0; nf = 1'b0; end
        if (have && e.good) begin
          if (!m_ready || ack) begin m_data = e.b; nr = 1'b1; end
          else no = 1'b1;
        end
        if (have && !e.good) nf = 1'b1;
        m_ready = nr; m_ovr = no; m_fe = nf;
      end
      #1;
      check("data_out", d4, m_data);
      check("ready", r4, m_ready);
      check("overrun", o4, m_ovr);
      check("frame_err", f4, m_fe);
      check("nibble_out", n4, nibble_sel ? m_data[7:4] : m_data[3:0]);
    end
  end

  task automatic set_rx(input bit big, input logic v);
    if (big) rx16 = v;
    else     rx4  = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge dblclk);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    @(negedge dblclk);
    rd_ack = 1'b0;
  endtask

  task automatic drive_frame(input bit big, input logic [7:0] b, input bit stop);
    int         c;
    logic [9:0] bits;
    c    = big ? 16 : 4;
    bits = {stop, b, 1'b0};
    if (!big) evq.push_back('{at: frame_done(c), good: stop, b: b});
    for (int i = 0; i < 10; i++) begin
      set_rx(big, bits[i]);
      repeat (c) @(negedge dblclk);
    end
  endtask

  // Frame plus an exact check of the cycle on which ready rises.
  task automatic frame_lat(input bit big, input logic [7:0] b);
    longint s;
    int     n;
    s = frame_done(big ? 16 : 4);
    n = int'(s - cyc) - 1;
    fork
      drive_frame(big, b, 1'b1);
      begin
        repeat (n) @(negedge dblclk);
        check("latency_before", big ? r16 : r4, 1'b0);
        @(negedge dblclk);
        check("latency_at", big ? r16 : r4, 1'b1);
        check("latency_data", big ? d16 : d4, b);
      end
    join
  endtask

  // Start bit and data bits 0..3 of 8'h0F, then half of data bit 4.
  task automatic drive_partial(input bit big);
    int         c;
    logic [9:0] bits;
    c    = big ? 16 : 4;
    bits = {1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_rx(big, bits[i]);
      repeat (c) @(negedge dblclk);
    end
    set_rx(big, bits[5]);
    repeat (c / 2) @(negedge dblclk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (vectors %0d)", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    check("reset_data", d4, 8'h00);
    check("reset_ready", r4, 1'b0);
    check("reset_ovr", o4, 1'b0);
    check("reset_fe", f4, 1'b0);
    reset = 1'b1;
    idle(3);

    // A5 with nibble view and ack
    frame_lat(1'b0, 8'hA5);
    idle(3);
    check("a5_ready", r4, 1'b1);
    check("a5_data", d4, 8'hA5);
    nibble_sel = 1'b1; #1;
    check("a5_nib_hi", n4, 4'hA);
    nibble_sel = 1'b0; #1;
    check("a5_nib_lo", n4, 4'h5);
    @(negedge dblclk);
    ack_pulse();
    check("a5_ack_ready", r4, 1'b0);
    check("a5_ack_data", d4, 8'hA5);

    // Overrun
    drive_frame(1'b0, 8'h3C, 1'b1);
    idle(3);
    drive_frame(1'b0, 8'hFF, 1'b1);
    idle(3);
    check("ovr_data", d4, 8'h3C);
    check("ovr_flag", o4, 1'b1);
    check("ovr_ready", r4, 1'b1);
    ack_pulse();
    check("ovr_ack_ready", r4, 1'b0);
    check("ovr_ack_flag", o4, 1'b0);

    // Framing error, line held low, ack mid-break must not re-raise it
    drive_frame(1'b0, 8'h81, 1'b0);
    idle(2);
    check("fe_flag", f4, 1'b1);
    check("fe_ready", r4, 1'b0);
    check("fe_data", d4, 8'h3C);
    ack_pulse();
    check("fe_ack", f4, 1'b0);
    idle(17);
    rx4 = 1'b1;
    idle(5);
    check("fe_once", f4, 1'b0);
    drive_frame(1'b0, 8'h42, 1'b1);
    idle(3);
    check("after_fe_ready", r4, 1'b1);
    check("after_fe_data", d4, 8'h42);
    ack_pulse();

    // One-cycle glitch
    rx4 = 1'b0;
    @(negedge dblclk);
    rx4 = 1'b1;
    idle(10);
    check("glitch_ready", r4, 1'b0);
    check("glitch_ovr", o4, 1'b0);
    check("glitch_fe", f4, 1'b0);

    // Ack coincides with the next frame's stop sample
    drive_frame(1'b0, 8'h11, 1'b1);
    idle(3);
    check("pre_5a_ready", r4, 1'b1);
    begin
      longint s;
      int     n;
      s = frame_done(4);
      n = int'(s - cyc) - 1;
      fork
        drive_frame(1'b0, 8'h5A, 1'b1);
        begin
          repeat (n) @(negedge dblclk);
          rd_ack = 1'b1;
          @(negedge dblclk);
          rd_ack = 1'b0;
        end
      join
    end
    idle(3);
    check("same_cyc_data", d4, 8'h5A);
    check("same_cyc_ready", r4, 1'b1);
    check("same_cyc_ovr", o4, 1'b0);
    ack_pulse();

    // Reset mid data bit 4, C=4
    drive_frame(1'b0, 8'h77, 1'b1);
    idle(3);
    drive_frame(1'b0, 8'hEE, 1'b1);
    idle(3);
    check("pre_rst_ovr", o4, 1'b1);
    evq.delete();
    drive_partial(1'b0);
    reset = 1'b0;
    #1;
    check("rst4_data", d4, 8'h00);
    check("rst4_ready", r4, 1'b0);
    check("rst4_ovr", o4, 1'b0);
    check("rst4_fe", f4, 1'b0);
    idle(3);
    rx4 = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(5);
    drive_frame(1'b0, 8'h0F, 1'b1);
    idle(3);
    check("rst4_0f_ready", r4, 1'b1);
    check("rst4_0f_data", d4, 8'h0F);
    ack_pulse();

    // CLKS_PER_BIT=16 instance
    frame_lat(1'b1, 8'hA5);
    idle(3);
    check("c16_a5_ready", r16, 1'b1);
    nibble_sel = 1'b1; #1;
    check("c16_nib_hi", n16, 4'hA);
    nibble_sel = 1'b0; #1;
    check("c16_nib_lo", n16, 4'h5);
    @(negedge dblclk);
    drive_frame(1'b1, 8'h66, 1'b1);
    idle(3);
    check("c16_ovr", o16, 1'b1);
    check("c16_ovr_data", d16, 8'hA5);
    drive_partial(1'b1);
    reset = 1'b0;
    #1;
    check("rst16_data", d16, 8'h00);
    check("rst16_ready", r16, 1'b0);
    check("rst16_ovr", o16, 1'b0);
    check("rst16_fe", f16, 1'b0);
    idle(3);
    rx16 = 1'b1;
    idle(1);
    reset = 1'b1;
    idle(5);
    frame_lat(1'b1, 8'h0F);
    idle(3);
    check("rst16_0f_ready", r16, 1'b1);
    check("rst16_0f_data", d16, 8'h0F);
    check("rst16_0f_fe", f16, 1'b0);
    ack_pulse();
    check("c16_ack_ready", r16, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver: the input-direction counterpart of the CPU's UART transmitter.
- Deserialises 8N1 frames from an asynchronous RX line into a holding register.
- Presents the byte to the 4-bit CPU datapath as a whole byte or as a selected nibble.
- Uses a ready/acknowledge handshake, with overrun and framing-error flags.

Parameters:
- CLKS_PER_BIT, 16, dblclk cycles per serial bit (integer ≥ 4).
- CNT_W, 8, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- dblclk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high; asynchronous to dblclk.
- rd_ack  input  1  CPU has consumed the held byte; single-cycle pulse.
- nibble_sel  input  1  0 selects data_out[3:0], 1 selects data_out[7:4] onto nibble_out.
- data_out  output  8  holding register: last good byte.
- nibble_out  output  4  combinational nibble of data_out chosen by nibble_sel.
- ready  output  1  holding register contains an unacknowledged byte.
- overrun  output  1  a good byte arrived while ready=1 and was dropped.
- frame_err  output  1  last frame had stop bit = 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; data_out=8'h00; ready=0; overrun=0; frame_err=0.
  - Counters cleared; synchroniser flops preset to 1.
- Input path: rx passes through a 2-flop synchroniser; all decisions use the synchronised value rxs.
- State machine:
  - IDLE: on rxs=0, go to START; bit counter = 0.
  - START: wait CLKS_PER_BIT/2 cycles (mid-bit) and sample rxs.
    - rxs=1: glitch; return to IDLE with no flag change.
    - rxs=0: go to DATA; counter restarts.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into shift[bit_idx].
    - LSB first; bit_idx counts 0..7.
    - After bit 7, go to STOP.
  - STOP: sample at mid-bit after CLKS_PER_BIT cycles.
    - rxs=1, ready=0: data_out←shift; ready←1; go to IDLE.
    - rxs=1, ready=1, rd_ack=1 in the same cycle: data_out←shift; ready stays 1; no overrun.
    - rxs=1, ready=1, rd_ack=0: data_out unchanged; overrun←1; go to IDLE.
    - rxs=0: frame_err←1; byte discarded; go to BREAK.
  - BREAK: remain until rxs=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Timing and latency:
  - ready rises the cycle after the STOP mid-bit sample.
  - That is ≈ 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the rx falling edge.
- Handshake:
  - rd_ack with ready=1 clears ready, overrun and frame_err on the next edge; data_out is held.
  - rd_ack with ready=0 clears only overrun and frame_err.
  - rd_ack held high for several cycles is harmless.
- Priority: a set event in a given cycle beats a clear from rd_ack for that same flag.
- Reception continues independent of ready; the receiver never stalls the line.
- Reset mid-frame: the frame is aborted and returns to IDLE. A line already low at reset release is treated as a new start bit.
- Counter wrap: the bit-timing counter reloads at CLKS_PER_BIT-1→0; bit_idx must never exceed 7.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/START/DATA/STOP/BREAK (3 bits);
  - UART_DATA_BITS=8;
  - default CLKS_PER_BIT.
  The transmitter uses the same constant for matched baud.
- One sub-module, uart_rx_sync: 2-flop synchroniser with asynchronous active-low reset, preset to 1.
- FSM, shifter and holding register stay in uart_rx.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset then send 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1):
  - ready=1, data_out=8'hA5;
  - nibble_sel=1 → nibble_out=4'hA; nibble_sel=0 → 4'h5;
  - rd_ack pulse → ready=0 next cycle, data_out still A5.
- Send 8'h3C, do not ack, send 8'hFF:
  - data_out stays 8'h3C; overrun=1; ready=1;
  - rd_ack → ready=0, overrun=0.
- Send 8'h81 with stop bit forced 0, then line held low 20 cycles, then high:
  - frame_err=1 exactly once; ready=0; data_out unchanged;
  - then send 8'h42 → ready=1, data_out=8'h42.
- rx low pulse of 1 cycle (shorter than half bit): receiver returns to IDLE; ready, overrun and frame_err all 0.
- Ready=1 and rd_ack asserted in the same cycle as the next frame's STOP sample (byte 8'h5A): data_out=8'h5A, ready=1, overrun=0.
- Assert reset low mid-way through data bit 4 of a frame:
  - all outputs return to reset values immediately;
  - after release, a clean 8'h0F frame is received correctly.
  - Rerun with CLKS_PER_BIT=16.
